// File: rtl/cnt_seq_checker.sv
// Receive-side monitor for a free-running up-counter stream.
// Locks onto the +1 sequence, counts discontinuities, flags wraps/restarts.
module cnt_seq_checker #(
    parameter int WIDTH         = 8,
    parameter int LOCK_CNT      = 4,
    parameter int LOSS_CNT      = 3,
    parameter int ERR_W         = 16,
    parameter int ALLOW_RESTART = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             restart_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
    localparam logic [BW-1:0] LOSS_V = BW'(LOSS_CNT);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state;
    logic             have_prev;
    logic [WIDTH-1:0] prev;
    logic [GW-1:0]    good_run;
    logic [BW-1:0]    bad_run;

    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] data_inc;
    logic [GW-1:0]    good_nxt;
    logic [BW-1:0]    bad_nxt;
    logic             is_match;
    logic             is_restart;
    logic             err_inc;

    always_comb begin
        prev_inc   = prev + 1'b1;
        data_inc   = in_data + 1'b1;
        good_nxt   = '0;
        if (have_prev && in_data == prev_inc)
            good_nxt = good_run + 1'b1;
        bad_nxt    = bad_run + 1'b1;
        is_match   = (in_data == expected);
        is_restart = (ALLOW_RESTART != 0) && (in_data == '0)
                     && (expected != '0);
        err_inc    = in_valid && (state == LOCKED)
                     && !is_match && !is_restart;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            have_prev     <= 1'b0;
            prev          <= '0;
            good_run      <= '0;
            bad_run       <= '0;
            locked        <= 1'b0;
            err_pulse     <= 1'b0;
            restart_pulse <= 1'b0;
            wrap_pulse    <= 1'b0;
            err_count     <= '0;
            expected      <= '0;
        end else begin
            err_pulse     <= 1'b0;
            restart_pulse <= 1'b0;
            wrap_pulse    <= 1'b0;

            // Clear has priority over a same-cycle increment.
            if (clear_err)
                err_count <= '0;
            else if (err_inc && err_count != {ERR_W{1'b1}})
                err_count <= err_count + 1'b1;

            if (in_valid) begin
                prev      <= in_data;
                have_prev <= 1'b1;
                unique case (state)
                    HUNT: begin
                        expected <= data_inc;
                        if (good_nxt == LOCK_V) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_run <= '0;
                            bad_run  <= '0;
                        end else begin
                            good_run <= good_nxt;
                        end
                    end
                    LOCKED: begin
                        if (is_match) begin
                            bad_run    <= '0;
                            expected   <= data_inc;
                            wrap_pulse <= (in_data == '0);
                        end else if (is_restart) begin
                            restart_pulse <= 1'b1;
                            bad_run       <= '0;
                            expected      <= WIDTH'(1);
                        end else begin
                            err_pulse <= 1'b1;
                            expected  <= data_inc;
                            if (bad_nxt == LOSS_V) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                good_run <= '0;
                                bad_run  <= '0;
                            end else begin
                                bad_run <= bad_nxt;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker: default, no-restart and 2-bit
// error counter instances driven from one shared stimulus stream.
module tb_cnt_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       clear_err = 1'b0;

    logic        locked, err_pulse, restart_pulse, wrap_pulse;
    logic [15:0] err_count;
    logic [7:0]  expected;

    logic        nr_locked, nr_err, nr_restart, nr_wrap;
    logic [15:0] nr_count;
    logic [7:0]  nr_expected;

    logic        e2_locked, e2_err, e2_restart, e2_wrap;
    logic [1:0]  e2_count;
    logic [7:0]  e2_expected;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cnt_seq_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
        .restart_pulse(restart_pulse), .wrap_pulse(wrap_pulse),
        .err_count(err_count), .expected(expected)
    );

    cnt_seq_checker #(.ALLOW_RESTART(0)) dut_nr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_err(clear_err), .locked(nr_locked), .err_pulse(nr_err),
        .restart_pulse(nr_restart), .wrap_pulse(nr_wrap),
        .err_count(nr_count), .expected(nr_expected)
    );

    cnt_seq_checker #(.ERR_W(2)) dut_e2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_err(clear_err), .locked(e2_locked), .err_pulse(e2_err),
        .restart_pulse(e2_restart), .wrap_pulse(e2_wrap),
        .err_count(e2_count), .expected(e2_expected)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic clr = 1'b0);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        clear_err = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_count", err_count, 0);
        check("rst_expected", expected, 0);
        check("rst_pulses", {err_pulse, restart_pulse, wrap_pulse}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Lock-on
        for (int v = 10; v <= 13; v++) send(8'(v));
        check("lock_early", locked, 0);
        send(14);
        check("lock_on", locked, 1);
        check("lock_exp", expected, 15);
        check("lock_cnt", err_count, 0);

        // Single glitch
        for (int v = 15; v <= 21; v++) send(8'(v));
        send(99);
        check("glitch_pulse", err_pulse, 1);
        check("glitch_cnt", err_count, 1);
        check("glitch_locked", locked, 1);
        check("glitch_exp", expected, 100);
        send(100);
        check("resync_pulse", err_pulse, 0);
        send(101);
        check("resync_cnt", err_count, 1);

        // Loss of lock and relock
        send(50);
        send(7);
        check("loss_mid", locked, 1);
        send(3);
        check("loss_cnt", err_count, 4);
        check("loss_unlock", locked, 0);
        send(9);
        check("hunt_nopulse", err_pulse, 0);
        check("hunt_locked", locked, 0);
        check("hunt_cnt", err_count, 4);
        send(10); send(11); send(12);
        check("relock_early", locked, 0);
        send(13);
        check("relock", locked, 1);
        check("relock_exp", expected, 14);
        check("e2_sat_a", e2_count, 3);

        // Wrap then restart
        send(253);
        check("jump_cnt", err_count, 5);
        send(254); send(255); send(0);
        check("wrap_pulse", wrap_pulse, 1);
        check("wrap_noerr", err_pulse, 0);
        check("wrap_exp", expected, 1);
        send(1); send(2); send(0);
        check("restart_pulse", restart_pulse, 1);
        check("restart_exp", expected, 1);
        check("restart_cnt", err_count, 5);
        check("restart_wrap", wrap_pulse, 0);
        check("nr_err", nr_err, 1);
        check("nr_restart", nr_restart, 0);
        check("nr_cnt", nr_count, 6);
        send(1);
        check("post_restart", err_pulse, 0);

        // Gaps across a locked run
        send(2); idle(3);
        check("gap_pulses", {err_pulse, restart_pulse, wrap_pulse}, 0);
        send(3); idle(1);
        send(4); send(5); idle(2);
        send(6);
        check("gap_cnt", err_count, 5);
        check("gap_locked", locked, 1);

        // Saturation of the 2-bit counter
        @(negedge clk);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check("clr_cnt", err_count, 0);
        check("clr_e2", e2_count, 0);
        send(100); send(101);
        send(150); send(151);
        send(30);
        check("e2_three", e2_count, 3);
        send(31);
        send(60); send(61);
        send(90);
        check("e2_sat", e2_count, 3);
        check("dut_five", err_count, 5);
        send(91);

        // Clear wins over a same-cycle mismatch
        send(200, 1'b1);
        check("clrwin_cnt", err_count, 0);
        check("clrwin_pulse", err_pulse, 1);
        check("clrwin_e2", e2_count, 0);
        send(201);
        send(50); send(51);
        send(80);
        check("pre_rst_cnt", err_count, 2);
        check("pre_rst_lock", locked, 1);

        // Reset mid-operation
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_locked", locked, 0);
        check("mrst_cnt", err_count, 0);
        check("mrst_exp", expected, 0);
        check("mrst_pulses", {err_pulse, restart_pulse, wrap_pulse}, 0);
        @(negedge clk);
        rst = 1'b0;
        send(81);
        check("first_locked", locked, 0);
        check("first_err", err_pulse, 0);
        check("first_exp", expected, 82);
        send(5);
        check("second_cnt", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
